circuit_pipe_dp: RTL and testbench
==================================

Name: circuit_pipe_dp

Overview:
- Parametrised, 3-stage pipelined version of the team's add/compare/mux/shift datapath.
- Computes d=a+b, e=a+c, f=a-b, g=(d<e)?d:e, h=(d==e)?g:f, x=g<<(lt·SHAMT), z=h>>(eq·SHAMT).
- Adds a valid/ready handshake on both ends with full backpressure, plus a signed/unsigned mode.
- Sits between an upstream operand producer and a downstream result consumer; accepts one operand set per cycle at full throughput.

Parameters:
- WIDTH, 32, datapath width of a, b, c, x, z and all internal values.
- SIGNED, 0, 0 = unsigned compare and logical right shift; 1 = two's-complement compare and arithmetic right shift.
- SHAMT, 1, shift distance applied when the lt/eq flag is 1; legal range 0..WIDTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  WIDTH  operand a.
- b  in  WIDTH  operand b.
- c  in  WIDTH  operand c.
- in_valid  in  1  operand set a/b/c is valid.
- in_ready  out  1  block accepts the operand set this cycle.
- x  out  WIDTH  result x.
- z  out  WIDTH  result z.
- out_valid  out  1  x/z hold a valid result.
- out_ready  in  1  consumer takes x/z this cycle.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: v1, v2, v3 clear to 0. All data registers, x and z clear to 0. out_valid=0 from the first edge with rst high. in_ready is forced 0 while rst=1.
- Transfers: input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage 1: registers d, e, f.
- Stage 2: registers g, h, lt, eq.
- Stage 3: registers x, z (drives the outputs directly); out_valid = v3.
- Advance rules:
  - adv3 = !v3 || out_ready.
  - adv2 = !v2 || adv3.
  - adv1 = !v1 || adv2.
  - in_ready = adv1 && !rst.
  - A stage loads its data and valid from the previous stage only when its adv is 1; otherwise it holds.
  - Valid bits follow the standard rule: stage i's valid takes stage i-1's valid when adv_i=1.
- Latency: exactly 3 cycles from an input transfer to out_valid, with no stalls. Throughput: 1 result per cycle.
- Stall: while out_ready=0 and out_valid=1, x, z and out_valid stay stable. The pipeline compresses bubbles and holds at most 3 in-flight results without loss. in_ready falls only when all three stages are valid and out_ready=0.
- Simultaneous events: a full pipeline with out_ready=1 accepts a new input in the same cycle (in_ready=1).
- Ordering: results leave in acceptance order; no duplicates, no drops.
- Arithmetic: add and subtract are modulo 2^WIDTH; carry and borrow are discarded.
- Comparison: lt and eq are computed on d and e per SIGNED.
- Shifts:
  - x = g shifted left by SHAMT when lt=1, else g, zero-filled.
  - z = h shifted right by SHAMT when eq=1, else h; zero-fill when SIGNED=0, sign-fill when SIGNED=1.
  - SHAMT=0 makes x=g and z=h.
- Reset mid-operation: all in-flight data is discarded. No output transfer occurs in any cycle where rst=1. Normal operation resumes on the first cycle after rst falls.
- in_valid while in_ready=0: the operands are ignored and must be held by the producer.

Test Plan:
1. WIDTH=32, SIGNED=0, SHAMT=1; a=5, b=3, c=7, out_ready=1 -> 3 cycles later out_valid=1, x=16, z=2 (d=8<e=12, g=8, h=f=2).
2. Same config; a=10, b=4, c=4 -> x=14, z=7 (d=e=14, eq=1, h=g=14, shifted right by 1).
3. Wrap-around: a=0xFFFFFFFF, b=1, c=2 -> d=0, e=1, lt=1; x=0, z=0xFFFFFFFE (f wraps); no carry side effects.
4. Signed mode, SIGNED=1; a=0, b=0xFFFFFFFB, c=3 -> lt=1 (-5<3); x=0xFFFFFFF6, z=5. Same vector with SIGNED=0 -> lt=0; x=3, z=5.
5. Backpressure: stream 5 back-to-back operand sets with out_ready=0 from the first out_valid.
   - in_ready drops after 3 are held; x/z stay stable.
   - Raise out_ready -> all 5 results appear in order, one per cycle, none lost or duplicated.
6. Reset mid-stream: assert rst for 1 cycle with 2 sets in flight -> next cycle out_valid=0, x=z=0, in_ready=0 during rst. After release the first new input yields its result 3 cycles later; no stale results appear.

Source files
------------

// File: rtl/circuit_pipe_dp.sv
// Three-stage add/compare/mux/shift datapath with valid/ready on both ends.
// Each stage holds whenever the stage after it is full and cannot move.
module circuit_pipe_dp #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0,
    parameter int SHAMT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] z,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] e;
        logic [WIDTH-1:0] f;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] h;
        logic             lt;
        logic             eq;
    } s2_t;

    s1_t s1;
    s2_t s2;
    s1_t s1_n;
    s2_t s2_n;
    logic [3:0]       vld_pipe;
    logic [3:1]       adv;
    logic [WIDTH-1:0] h_sra;
    logic [WIDTH-1:0] x_n;
    logic [WIDTH-1:0] z_n;

    assign vld_pipe[0] = in_valid;
    assign adv[3]      = !vld_pipe[3] || out_ready;
    assign adv[2]      = !vld_pipe[2] || adv[3];
    assign adv[1]      = !vld_pipe[1] || adv[2];
    assign in_ready    = adv[1] && !rst;
    // Masked during reset so no output transfer can complete in a reset cycle.
    assign out_valid   = vld_pipe[3] && !rst;

    always_comb begin
        s1_n.d = a + b;
        s1_n.e = a + c;
        s1_n.f = a - b;
    end

    always_comb begin
        s2_n.lt = 1'b0;
        if (SIGNED) s2_n.lt = $signed(s1.d) < $signed(s1.e);
        else        s2_n.lt = s1.d < s1.e;
        s2_n.eq = (s1.d == s1.e);
        s2_n.g  = s2_n.lt ? s1.d : s1.e;
        s2_n.h  = s2_n.eq ? s2_n.g : s1.f;
    end

    // Signedness of the shift comes from the operand alone, so this is a true sign-fill shift.
    assign h_sra = $signed(s2.h) >>> SHAMT;

    always_comb begin
        x_n = s2.lt ? (s2.g << SHAMT) : s2.g;
        z_n = s2.h;
        if (s2.eq) z_n = SIGNED ? h_sra : (s2.h >> SHAMT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[3:1] <= '0;
            s1            <= '0;
            s2            <= '0;
            x             <= '0;
            z             <= '0;
        end else begin
            for (int i = 1; i <= 3; i++)
                if (adv[i]) vld_pipe[i] <= vld_pipe[i-1];
            if (adv[1]) s1 <= s1_n;
            if (adv[2]) s2 <= s2_n;
            if (adv[3]) begin
                x <= x_n;
                z <= z_n;
            end
        end
    end

endmodule

// File: tb/tb_circuit_pipe_dp.sv
// Bench for circuit_pipe_dp: unsigned and signed instances share one stimulus stream,
// results are checked against an arithmetic reference model and a FIFO scoreboard.
module tb_circuit_pipe_dp;

    typedef struct packed {
        logic [31:0] xu;
        logic [31:0] zu;
        logic [31:0] xs;
        logic [31:0] zs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b, c;
    logic        in_valid, out_ready;
    logic        in_ready_u, in_ready_s, out_valid_u, out_valid_s;
    logic [31:0] x_u, z_u, x_s, z_s;

    int   checks = 0;
    int   passed = 0;
    int   popped = 0;
    bit   acc    = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    circuit_pipe_dp #(.WIDTH(32), .SIGNED(1'b0), .SHAMT(1)) u_uns (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .in_valid(in_valid), .in_ready(in_ready_u),
        .x(x_u), .z(z_u), .out_valid(out_valid_u), .out_ready(out_ready)
    );

    circuit_pipe_dp #(.WIDTH(32), .SIGNED(1'b1), .SHAMT(1)) u_sgn (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .x(x_s), .z(z_s), .out_valid(out_valid_s), .out_ready(out_ready)
    );

    // Reference: plain modular arithmetic, min/select, shift by 1 as *2 and floor(/2).
    function automatic logic [63:0] model(input logic [31:0] va, vb, vc, input bit sgn);
        logic [31:0] d, e, f, g, h, xr, zr;
        bit lt, eq;
        int s;
        d = va + vb;
        e = va + vc;
        f = va - vb;
        if (sgn) lt = $signed(d) < $signed(e);
        else     lt = d < e;
        eq = (d == e);
        g  = lt ? d : e;
        h  = eq ? g : f;
        xr = lt ? g * 2 : g;
        zr = h;
        if (eq) begin
            if (sgn) begin
                s  = $signed(h);
                zr = (s < 0) ? (s - 1) / 2 : s / 2;
            end else begin
                zr = h / 2;
            end
        end
        return {xr, zr};
    endfunction

    function automatic exp_t expect_of(input logic [31:0] va, vb, vc);
        exp_t r;
        {r.xu, r.zu} = model(va, vb, vc, 1'b0);
        {r.xs, r.zs} = model(va, vb, vc, 1'b1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: monitor transfers at the falling edge, then advance past the rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        acc = 1'b0;
        chk("in_ready_rule", 32'(in_ready_u), 32'(!rst && !(q.size() == 3 && !out_ready)));
        chk("in_ready_sgn", 32'(in_ready_s), 32'(in_ready_u));
        chk("out_valid_sgn", 32'(out_valid_s), 32'(out_valid_u));
        if (out_valid_u && out_ready) begin
            chk("out_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                popped++;
                chk("sb_x_uns", x_u, e.xu);
                chk("sb_z_uns", z_u, e.zu);
                chk("sb_x_sgn", x_s, e.xs);
                chk("sb_z_sgn", z_s, e.zs);
            end
        end
        if (in_valid && in_ready_u) begin
            q.push_back(expect_of(a, b, c));
            acc = 1'b1;
        end
        @(posedge clk);
        if (rst) q.delete();
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] va, vb, vc,
                            input logic [31:0] ex, ez, input bit chk_sgn,
                            input logic [31:0] exs, ezs);
        out_ready = 1'b1;
        a = va; b = vb; c = vc;
        in_valid = 1'b1;
        cyc();
        chk({tag, "_accept"}, 32'(acc), 32'd1);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid_u), 32'd0);
        cyc();
        chk({tag, "_lat2"}, 32'(out_valid_u), 32'd0);
        cyc();
        chk({tag, "_lat3"}, 32'(out_valid_u), 32'd1);
        chk({tag, "_x"}, x_u, ex);
        chk({tag, "_z"}, z_u, ez);
        if (chk_sgn) begin
            chk({tag, "_xs"}, x_s, exs);
            chk({tag, "_zs"}, z_s, ezs);
        end
        cyc();
    endtask

    task automatic rand_ops();
        case ($urandom_range(0, 3))
            0: begin a = $urandom; b = $urandom; c = b; end
            1: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); c = $urandom_range(0, 15); end
            2: begin a = $urandom; b = 32'hFFFF_FFF0 | $urandom_range(0, 15); c = $urandom_range(0, 15); end
            default: begin a = $urandom; b = $urandom; c = $urandom; end
        endcase
    endtask

    initial begin
        logic [31:0] va[5], vb[5], vc[5];
        logic [31:0] hx, hz;
        exp_t r;
        int k, p0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c = '0;
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid_u), 32'd0);
        chk("rst_x", x_u, 32'd0);
        chk("rst_z", z_u, 32'd0);
        chk("rst_in_ready", 32'(in_ready_u), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready_u), 32'd1);

        directed("lt_case", 32'd5, 32'd3, 32'd7, 32'd16, 32'd2, 1'b1, 32'd16, 32'd2);
        directed("eq_case", 32'd10, 32'd4, 32'd4, 32'd14, 32'd7, 1'b1, 32'd14, 32'd7);
        directed("wrap", 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd0, 32'hFFFF_FFFE, 1'b0, 32'd0, 32'd0);
        directed("sign_mode", 32'd0, 32'hFFFF_FFFB, 32'd3, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFF6, 32'd5);
        directed("neg_eq", 32'hFFFF_FFF0, 32'd1, 32'd1, 32'hFFFF_FFF1, 32'h7FFF_FFF8, 1'b1,
                 32'hFFFF_FFF1, 32'hFFFF_FFF8);

        // Backpressure: five back-to-back sets against a stalled consumer.
        for (int i = 0; i < 5; i++) begin va[i] = $urandom; vb[i] = $urandom; vc[i] = $urandom; end
        out_ready = 1'b0;
        k = 0;
        a = va[0]; b = vb[0]; c = vc[0]; in_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cyc();
            if (acc) begin k++; a = va[k]; b = vb[k]; c = vc[k]; end
        end
        chk("bp_accepted3", 32'(k), 32'd3);
        chk("bp_in_ready_low", 32'(in_ready_u), 32'd0);
        chk("bp_out_valid", 32'(out_valid_u), 32'd1);
        hx = x_u; hz = z_u;
        for (int t = 0; t < 3; t++) begin
            cyc();
            chk("bp_hold_x", x_u, hx);
            chk("bp_hold_z", z_u, hz);
            chk("bp_hold_ready", 32'(in_ready_u), 32'd0);
            chk("bp_hold_noacc", 32'(acc), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("full_accept_ready", 32'(in_ready_u), 32'd1);
        p0 = popped;
        for (int t = 0; t < 5; t++) begin
            chk("bp_stream_valid", 32'(out_valid_u), 32'd1);
            cyc();
            if (acc) begin
                k++;
                if (k < 5) begin a = va[k]; b = vb[k]; c = vc[k]; end
                else in_valid = 1'b0;
            end
        end
        chk("bp_result_count", 32'(popped - p0), 32'd5);
        chk("bp_queue_empty", 32'(q.size()), 32'd0);

        // Random traffic with random stalls; producer holds unaccepted operands.
        in_valid = 1'b0; acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_ops();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) cyc();
        chk("rand_drain_empty", 32'(q.size()), 32'd0);

        // Reset with two sets in flight.
        out_ready = 1'b1;
        rand_ops(); in_valid = 1'b1;
        cyc();
        rand_ops();
        cyc();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready_u), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid_u), 32'd0);
        cyc();
        chk("mid_rst_ov_after", 32'(out_valid_u), 32'd0);
        chk("mid_rst_x", x_u, 32'd0);
        chk("mid_rst_z", z_u, 32'd0);
        rst = 1'b0;
        #1;
        r = expect_of(32'd123, 32'd77, 32'd200);
        directed("after_rst", 32'd123, 32'd77, 32'd200, r.xu, r.zu, 1'b1, r.xs, r.zs);
        repeat (4) cyc();
        chk("after_rst_no_stale", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
